dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_arbiter_rr.sv | 33 +++
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_pkg;

  localparam int NUM_PORTS     = 2;
  localparam int ADDR_W_DEF    = 32;
  localparam int MEM_BYTES_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin grant: a lone requester wins, ties go to the pointer,
// and the pointer moves to the other port after each accepted request.
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] valid,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant
);

  logic ptr;

  always_comb begin
    grant = '0;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter onto a 32-bit data memory; double accesses take two beats.
// Optional alignment check is enabled with DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req_valid,
  output logic [NUM_PORTS-1:0] req_ready,
  input  logic [NUM_PORTS-1:0] req_we,
  input  logic [NUM_PORTS-1:0] req_sb,
  input  logic [NUM_PORTS-1:0] req_dbl,
  input  logic [ADDR_W-1:0]    req_addr0,
  input  logic [ADDR_W-1:0]    req_addr1,
  input  logic [63:0]          req_wdata0,
  input  logic [63:0]          req_wdata1,
  output logic [NUM_PORTS-1:0] rsp_valid,
  output logic [63:0]          rsp_rdata,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic                 mem_sb,
  input  logic [31:0]          mem_rdata,
  output logic [NUM_PORTS-1:0] err,
  output state_e               state_dbg
);

  // The memory wraps addresses itself; it must be a power of two of at least two words.
  if (MEM_BYTES < 8 || (MEM_BYTES & (MEM_BYTES - 1)) != 0) begin : g_bad_mem_bytes
    $error("MEM_BYTES must be a power of two of at least 8");
  end

  // Handshake: a request moves when req_valid[p] and req_ready[p] are both high
  // at a rising edge; req_ready is only ever high in IDLE for the granted port.
  state_e               state;
  state_e               state_nxt;
  logic [NUM_PORTS-1:0] grant;
  logic                 accept;
  logic                 sel;
  logic                 owner;
  logic                 misalign;
  logic [ADDR_W-1:0]    sel_addr;
  logic [63:0]          sel_wdata;
  logic                 sel_we;
  logic                 sel_sb;
  logic                 sel_dbl;
  logic [ADDR_W-1:0]    addr_q;
  logic [63:0]          wdata_q;
  logic                 we_q;
  logic                 sb_q;
  logic                 dbl_q;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign accept    = (state == ST_IDLE) && (grant != '0);
  assign req_ready = (state == ST_IDLE) ? grant : '0;
  assign sel       = grant[1];
  assign state_dbg = state;

  always_comb begin
    sel_addr  = sel ? req_addr1  : req_addr0;
    sel_wdata = sel ? req_wdata1 : req_wdata0;
    sel_we    = sel ? req_we[1]  : req_we[0];
    sel_sb    = sel ? req_sb[1]  : req_sb[0];
    sel_dbl   = sel ? req_dbl[1] : req_dbl[0];
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic err_q;

  assign misalign = (!sel_sb && sel_addr[1:0] != 2'b00) || (sel_dbl && sel_addr[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misalign;
    end
  end

  assign err = (state == ST_RESP && err_q) ? {owner, !owner} : '0;
`else
  assign misalign = 1'b0;
  assign err      = '0;
`endif

  // dbl only matters for word accesses; a store-byte is always a single beat.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = misalign ? ST_RESP : ST_BEAT0;
      ST_BEAT0: state_nxt = (dbl_q && !sb_q) ? ST_BEAT1 : ST_RESP;
      ST_BEAT1: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      sb_q      <= 1'b0;
      dbl_q     <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner   <= sel;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        we_q    <= sel_we;
        sb_q    <= sel_sb;
        dbl_q   <= sel_dbl;
      end
      // Only reads update the response data; the low word survives single reads.
      if (state == ST_BEAT0 && !we_q) rsp_rdata[63:32] <= mem_rdata;
      if (state == ST_BEAT1 && !we_q) rsp_rdata[31:0]  <= mem_rdata;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_sb    = 1'b0;
    if (state == ST_BEAT0 || state == ST_BEAT1) begin
      mem_addr  = (state == ST_BEAT1) ? addr_q + ADDR_W'(4) : addr_q;
      mem_wdata = (state == ST_BEAT1) ? wdata_q[31:0] : wdata_q[63:32];
      mem_we    = we_q;
      mem_re    = !we_q;
      mem_sb    = sb_q;
    end
  end

  assign rsp_valid = (state == ST_RESP) ? {owner, !owner} : '0;

endmodule
